// File: rtl/arch_rat.sv
// Architectural (committed) register alias table: four in-order commit slots per cycle,
// registered freed-tag outputs and a full-table recovery image for mispredict restore.
module arch_rat (
    input  logic         clock,
    input  logic         reset,
    input  logic         commit0_we_i,
    input  logic [4:0]   commit0_ard_i,
    input  logic [6:0]   commit0_prd_i,
    input  logic         commit1_we_i,
    input  logic [4:0]   commit1_ard_i,
    input  logic [6:0]   commit1_prd_i,
    input  logic         commit2_we_i,
    input  logic [4:0]   commit2_ard_i,
    input  logic [6:0]   commit2_prd_i,
    input  logic         commit3_we_i,
    input  logic [4:0]   commit3_ard_i,
    input  logic [6:0]   commit3_prd_i,
    input  logic         commit_stall_i,
    input  logic         rec_req_i,
    output logic         rec_valid_o,
    output logic [223:0] arch_rat_rec_data_o,
    output logic         free0_valid_o,
    output logic [6:0]   free0_prd_o,
    output logic         free1_valid_o,
    output logic [6:0]   free1_prd_o,
    output logic         free2_valid_o,
    output logic [6:0]   free2_prd_o,
    output logic         free3_valid_o,
    output logic [6:0]   free3_prd_o
);

    logic [6:0] table_r [32];
    logic [6:0] table_nxt_s [32];
    logic [3:0] we_s;
    logic [3:0] eff_s;
    logic [4:0] ard_s [4];
    logic [6:0] prd_s [4];
    logic [6:0] tag_s [4];
    logic [3:0] free_valid_r;
    logic [6:0] free_prd_r [4];
    logic       rec_valid_r;

    assign we_s     = {commit3_we_i, commit2_we_i, commit1_we_i, commit0_we_i};
    assign ard_s[0] = commit0_ard_i;
    assign ard_s[1] = commit1_ard_i;
    assign ard_s[2] = commit2_ard_i;
    assign ard_s[3] = commit3_ard_i;
    assign prd_s[0] = commit0_prd_i;
    assign prd_s[1] = commit1_prd_i;
    assign prd_s[2] = commit2_prd_i;
    assign prd_s[3] = commit3_prd_i;

    // Freed tags with intra-group forwarding, and the next table image (later slots win).
    always_comb begin
        eff_s = we_s & {4{~commit_stall_i}};
        for (int k = 0; k < 4; k++) begin
            tag_s[k] = table_r[ard_s[k]];
            for (int j = 0; j < k; j++) begin
                tag_s[k] = (eff_s[j] && (ard_s[j] == ard_s[k])) ? prd_s[j] : tag_s[k];
            end
            // The zero register is never live, so its new tag is released immediately.
            tag_s[k] = (ard_s[k] == 5'd31) ? prd_s[k] : tag_s[k];
        end
        for (int i = 0; i < 32; i++) begin
            table_nxt_s[i] = table_r[i];
            for (int k = 0; k < 4; k++) begin
                table_nxt_s[i] = (eff_s[k] && (ard_s[k] == 5'(i)) && (ard_s[k] != 5'd31))
                                 ? prd_s[k] : table_nxt_s[i];
            end
        end
    end

    // Table, free-port and recovery-valid registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                table_r[i] <= 7'(i);
            end
            for (int k = 0; k < 4; k++) begin
                free_prd_r[k] <= 7'd0;
            end
            free_valid_r <= 4'd0;
            rec_valid_r  <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                table_r[i] <= table_nxt_s[i];
            end
            for (int k = 0; k < 4; k++) begin
                if (eff_s[k]) begin
                    free_prd_r[k] <= tag_s[k];
                end
            end
            free_valid_r <= eff_s;
            rec_valid_r  <= rec_req_i;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_img
        assign arch_rat_rec_data_o[7*g +: 7] = table_r[g];
    end

    assign rec_valid_o   = rec_valid_r;
    assign free0_valid_o = free_valid_r[0];
    assign free1_valid_o = free_valid_r[1];
    assign free2_valid_o = free_valid_r[2];
    assign free3_valid_o = free_valid_r[3];
    assign free0_prd_o   = free_prd_r[0];
    assign free1_prd_o   = free_prd_r[1];
    assign free2_prd_o   = free_prd_r[2];
    assign free3_prd_o   = free_prd_r[3];

endmodule

// File: tb/tb_arch_rat.sv
// Self-checking bench for arch_rat: hand-derived vector table, then random traffic
// checked against a slot-by-slot sequential reference model through a scoreboard queue.
module tb_arch_rat;

    typedef struct packed {
        logic            rst;
        logic            rec;
        logic            stall;
        logic [3:0]      we;
        logic [3:0][4:0] ard;
        logic [3:0][6:0] prd;
        logic [3:0]      fv;
        logic [3:0][6:0] fp;
        logic            rv;
        logic            echk;
        logic [4:0]      eidx;
        logic [6:0]      eval;
    } vec_t;

    typedef struct packed {
        logic [3:0]      fv;
        logic [3:0][6:0] fp;
        logic            rv;
        logic [223:0]    img;
    } exp_t;

    logic            clock;
    logic            reset;
    logic [3:0]      we;
    logic [3:0][4:0] ard;
    logic [3:0][6:0] prd;
    logic            stall;
    logic            rec;
    logic            rv_o;
    logic [223:0]    img_o;
    logic [3:0]      fv_o;
    logic [3:0][6:0] fp_o;

    logic [6:0] mdl [32];
    exp_t       sb_q [$];
    vec_t       vecs [13];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    arch_rat dut (
        .clock(clock), .reset(reset),
        .commit0_we_i(we[0]), .commit0_ard_i(ard[0]), .commit0_prd_i(prd[0]),
        .commit1_we_i(we[1]), .commit1_ard_i(ard[1]), .commit1_prd_i(prd[1]),
        .commit2_we_i(we[2]), .commit2_ard_i(ard[2]), .commit2_prd_i(prd[2]),
        .commit3_we_i(we[3]), .commit3_ard_i(ard[3]), .commit3_prd_i(prd[3]),
        .commit_stall_i(stall), .rec_req_i(rec),
        .rec_valid_o(rv_o), .arch_rat_rec_data_o(img_o),
        .free0_valid_o(fv_o[0]), .free0_prd_o(fp_o[0]),
        .free1_valid_o(fv_o[1]), .free1_prd_o(fp_o[1]),
        .free2_valid_o(fv_o[2]), .free2_prd_o(fp_o[2]),
        .free3_valid_o(fv_o[3]), .free3_prd_o(fp_o[3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [223:0] act, input logic [223:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [223:0] pack_mdl();
        logic [223:0] r;
        for (int i = 0; i < 32; i++) r[7*i +: 7] = mdl[i];
        return r;
    endfunction

    // Reference: process slots strictly one after another against a live copy of the table.
    function automatic exp_t model_step(input vec_t v);
        exp_t e;
        e.fv = 4'd0;
        e.fp = '0;
        e.rv = v.rec & ~v.rst;
        if (v.rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 7'(i);
        end else if (!v.stall) begin
            for (int k = 0; k < 4; k++) begin
                if (v.we[k]) begin
                    e.fv[k] = 1'b1;
                    if (v.ard[k] == 5'd31) begin
                        e.fp[k] = v.prd[k];
                    end else begin
                        e.fp[k] = mdl[v.ard[k]];
                        mdl[v.ard[k]] = v.prd[k];
                    end
                end
            end
        end
        e.img = pack_mdl();
        return e;
    endfunction

    function automatic vec_t mkv(input logic rst_v, input logic rec_v, input logic st_v,
                                 input logic [3:0] we_v,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [4:0] a2, input logic [4:0] a3,
                                 input logic [6:0] p0, input logic [6:0] p1,
                                 input logic [6:0] p2, input logic [6:0] p3,
                                 input logic [3:0] fv_v,
                                 input logic [6:0] f0, input logic [6:0] f1,
                                 input logic [6:0] f2, input logic [6:0] f3,
                                 input logic rv_v, input logic echk_v,
                                 input logic [4:0] eidx_v, input logic [6:0] eval_v);
        vec_t v;
        v.rst = rst_v; v.rec = rec_v; v.stall = st_v; v.we = we_v;
        v.ard = {a3, a2, a1, a0};
        v.prd = {p3, p2, p1, p0};
        v.fv = fv_v;
        v.fp = {f3, f2, f1, f0};
        v.rv = rv_v; v.echk = echk_v; v.eidx = eidx_v; v.eval = eval_v;
        return v;
    endfunction

    task automatic step(input vec_t v, input logic use_hand);
        exp_t e;
        exp_t got;
        e = model_step(v);
        if (use_hand) begin
            e.fv = v.fv;
            e.fp = v.fp;
            e.rv = v.rv;
        end
        reset = v.rst; rec = v.rec; stall = v.stall;
        we = v.we; ard = v.ard; prd = v.prd;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        chk("free_valid", 224'(fv_o), 224'(got.fv));
        for (int k = 0; k < 4; k++) begin
            if (got.fv[k]) chk($sformatf("free%0d_prd", k), 224'(fp_o[k]), 224'(got.fp[k]));
        end
        chk("rec_valid", 224'(rv_o), 224'(got.rv));
        chk("image", img_o, got.img);
        if (v.echk) chk($sformatf("entry%0d", v.eidx), 224'(img_o[7*v.eidx +: 7]), 224'(v.eval));
    endtask

    initial begin
        vec_t rv;
        reset = 1'b1; rec = 1'b0; stall = 1'b0; we = 4'd0; ard = '0; prd = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 7'(i);

        //            rst   rec   stl   we     ard0..3                   prd0..3                      fv     free0..3                     rv    chk   idx    val
        vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0,     7'd0,  7'd0,  7'd0,  7'd0,   4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd31, 7'd31);
        vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 5'd5, 5'd0, 5'd0, 5'd0,     7'd40, 7'd0,  7'd0,  7'd0,   4'h1, 7'd5, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd5,  7'd40);
        vecs[2]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 5'd5, 5'd0, 5'd0, 5'd0,     7'd41, 7'd0,  7'd0,  7'd0,   4'h1, 7'd40, 7'd0, 7'd0,  7'd0,  1'b0, 1'b1, 5'd5,  7'd41);
        vecs[3]  = mkv(1'b0, 1'b0, 1'b0, 4'hf, 5'd3, 5'd3, 5'd3, 5'd3,     7'd50, 7'd51, 7'd52, 7'd53,  4'hf, 7'd3, 7'd50, 7'd51, 7'd52, 1'b0, 1'b1, 5'd3,  7'd53);
        vecs[4]  = mkv(1'b0, 1'b0, 1'b0, 4'h2, 5'd0, 5'd31, 5'd0, 5'd0,    7'd0,  7'd60, 7'd0,  7'd0,   4'h2, 7'd0, 7'd60, 7'd0,  7'd0,  1'b0, 1'b1, 5'd31, 7'd31);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b1, 4'h3, 5'd4, 5'd31, 5'd0, 5'd0,    7'd65, 7'd60, 7'd0,  7'd0,   4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd4,  7'd4);
        vecs[6]  = mkv(1'b0, 1'b1, 1'b0, 4'h4, 5'd0, 5'd0, 5'd7, 5'd0,     7'd0,  7'd0,  7'd70, 7'd0,   4'h4, 7'd0, 7'd0,  7'd7,  7'd0,  1'b1, 1'b1, 5'd7,  7'd70);
        vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 4'h1, 5'd8, 5'd0, 5'd0, 5'd0,     7'd80, 7'd0,  7'd0,  7'd0,   4'h1, 7'd8, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd8,  7'd80);
        vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0,     7'd0,  7'd0,  7'd0,  7'd0,   4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b1, 1'b0, 5'd0,  7'd0);
        vecs[9]  = mkv(1'b0, 1'b1, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0,     7'd0,  7'd0,  7'd0,  7'd0,   4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b1, 1'b0, 5'd0,  7'd0);
        vecs[10] = mkv(1'b0, 1'b0, 1'b0, 4'hd, 5'd9, 5'd9, 5'd9, 5'd10,    7'd90, 7'd91, 7'd92, 7'd100, 4'hd, 7'd9, 7'd0,  7'd90, 7'd10, 1'b0, 1'b1, 5'd9,  7'd92);
        vecs[11] = mkv(1'b1, 1'b1, 1'b0, 4'hf, 5'd1, 5'd2, 5'd5, 5'd31,    7'd11, 7'd12, 7'd13, 7'd14,  4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd5,  7'd5);
        vecs[12] = mkv(1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 5'd0,     7'd0,  7'd0,  7'd0,  7'd0,   4'h0, 7'd0, 7'd0,  7'd0,  7'd0,  1'b0, 1'b1, 5'd1,  7'd1);

        repeat (2) @(posedge clock);
        #1;
        chk("reset_rec_valid", 224'(rv_o), 224'(1'b0));
        chk("reset_free_valid", 224'(fv_o), 224'(4'h0));
        chk("reset_free_prd", 224'(fp_o), 224'(28'h0));
        chk("reset_entry1", 224'(img_o[13:7]), 224'(7'd1));
        chk("reset_entry31", 224'(img_o[223:217]), 224'(7'd31));
        chk("reset_image", img_o, pack_mdl());

        for (int i = 0; i < 13; i++) step(vecs[i], 1'b1);

        // Random traffic with dense ard collisions, zero-register slots, stalls and resets.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = '0;
            v.rst   = ($urandom_range(0, 59) == 0);
            v.rec   = ($urandom_range(0, 3) == 0);
            v.stall = ($urandom_range(0, 7) == 0);
            v.we    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                v.ard[k] = 5'($urandom_range(0, 7));
                if (v.ard[k] == 5'd7) v.ard[k] = 5'd31;
                v.prd[k] = 7'($urandom_range(0, 127));
            end
            step(v, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
